// File: rtl/midi_msg_assembler_if.sv
// midi_msg_assembler_if: byte-stream input and framed-message output of the MIDI message assembler.
// The slave modport is the assembler; the master modport is the receiver/parser side.
interface midi_msg_assembler_if;
  logic [7:0] in_byte;
  logic       in_byte_ready;
  logic [7:0] out_status;
  logic [6:0] out_data1;
  logic [6:0] out_data2;
  logic       out_valid;
  logic [7:0] out_realtime;
  logic       out_realtime_valid;
  logic       out_error;

  modport master (
    output in_byte, in_byte_ready,
    input  out_status, out_data1, out_data2, out_valid,
    input  out_realtime, out_realtime_valid, out_error
  );

  modport slave (
    input  in_byte, in_byte_ready,
    output out_status, out_data1, out_data2, out_valid,
    output out_realtime, out_realtime_valid, out_error
  );
endinterface

// File: rtl/midi_msg_assembler.sv
// midi_msg_assembler: frames raw MIDI bytes into messages (running status, real-time, SysEx skip,
// stall timeout). Optional build macro MIDI_CHANNEL_FILTER_EN passes only channel CHANNEL.
module midi_msg_assembler #(
  parameter int TIMEOUT_CYCLES = 441,
  parameter int CHANNEL        = 0
) (
  input logic                 clock,
  input logic                 reset_n,
  midi_msg_assembler_if.slave bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("midi_msg_assembler: TIMEOUT_CYCLES must be at least 1");
  end
  if (CHANNEL < 0 || CHANNEL > 15) begin : g_bad_channel
    $error("midi_msg_assembler: CHANNEL must be 0..15");
  end

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_D1 = 2'd1;
  localparam logic [1:0] WAIT_D2 = 2'd2;
  localparam logic [1:0] SYSEX   = 2'd3;

  localparam int            CW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [7:0]    rs_q, rs_d;
  logic [6:0]    d1_q, d1_d;
  logic [CW-1:0] cnt_q;

  logic       emit, emit_ok, err;
  logic [7:0] emit_status;
  logic [6:0] emit_d1, emit_d2;
  logic       is_rt, timeout_hit;

  function automatic logic one_data(input logic [7:0] s);
    return (s[7:5] == 3'b110) || (s == 8'hF1) || (s == 8'hF3);
  endfunction

  assign is_rt       = bus.in_byte_ready && (bus.in_byte[7:3] == 5'b11111);
  // Expiry is the idle cycle that moves the counter onto TIMEOUT_CYCLES; any byte suppresses it.
  assign timeout_hit = !bus.in_byte_ready && (cnt_q == T_LAST);

`ifdef MIDI_CHANNEL_FILTER_EN
  assign emit_ok = (emit_status[7:4] == 4'hF) || (emit_status[3:0] == CHANNEL[3:0]);
`else
  assign emit_ok = 1'b1;
`endif

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no latch can be inferred.
    state_d     = state_q;
    rs_d        = rs_q;
    d1_d        = d1_q;
    emit        = 1'b0;
    emit_status = rs_q;
    emit_d1     = 7'd0;
    emit_d2     = 7'd0;
    err         = 1'b0;
    if (bus.in_byte_ready && !is_rt) begin
      if (bus.in_byte[7]) begin
        d1_d = 7'd0;
        if (bus.in_byte < 8'hF0) begin
          rs_d    = bus.in_byte;
          state_d = WAIT_D1;
        end else begin
          case (bus.in_byte)
            8'hF0: begin
              rs_d    = 8'h00;
              state_d = SYSEX;
            end
            8'hF1, 8'hF2, 8'hF3: begin
              rs_d    = bus.in_byte;
              state_d = WAIT_D1;
            end
            8'hF6: begin
              rs_d        = 8'h00;
              state_d     = IDLE;
              emit        = 1'b1;
              emit_status = 8'hF6;
            end
            default: begin
              rs_d    = 8'h00;
              state_d = IDLE;
            end
          endcase
        end
      end else begin
        case (state_q)
          IDLE: err = 1'b1;
          WAIT_D1: begin
            if (one_data(rs_q)) begin
              emit    = 1'b1;
              emit_d1 = bus.in_byte[6:0];
              // System common messages never become running status.
              if (rs_q[7:4] == 4'hF) begin
                rs_d    = 8'h00;
                state_d = IDLE;
              end
            end else begin
              d1_d    = bus.in_byte[6:0];
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            emit    = 1'b1;
            emit_d1 = d1_q;
            emit_d2 = bus.in_byte[6:0];
            d1_d    = 7'd0;
            if (rs_q == 8'hF2) begin
              rs_d    = 8'h00;
              state_d = IDLE;
            end else begin
              state_d = WAIT_D1;
            end
          end
          default: ;
        endcase
      end
    end else if (timeout_hit && state_q == WAIT_D2) begin
      state_d = WAIT_D1;
      d1_d    = 7'd0;
      err     = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rs_q    <= 8'h00;
      d1_q    <= 7'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      d1_q    <= d1_d;
      if (bus.in_byte_ready) begin
        if (!is_rt) cnt_q <= '0;
      end else if (cnt_q != T_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_status         <= 8'h00;
      bus.out_data1          <= 7'd0;
      bus.out_data2          <= 7'd0;
      bus.out_valid          <= 1'b0;
      bus.out_realtime       <= 8'h00;
      bus.out_realtime_valid <= 1'b0;
      bus.out_error          <= 1'b0;
    end else begin
      bus.out_valid          <= emit && emit_ok;
      bus.out_realtime_valid <= is_rt;
      bus.out_error          <= err;
      if (emit && emit_ok) begin
        bus.out_status <= emit_status;
        bus.out_data1  <= emit_d1;
        bus.out_data2  <= emit_d2;
      end
      if (is_rt) bus.out_realtime <= bus.in_byte;
    end
  end

endmodule
